// File: rtl/cpu_bus_router_if.sv
// CPU-side bus of the B322 router: request from the CPU, read data and completion back.
interface cpu_bus_router_if;
    logic [26:0] bus_addr;
    logic [31:0] bus_data;
    logic        bus_we;
    logic        bus_start;
    logic [31:0] bus_q;
    logic        bus_done;
    logic        bus_err;

    modport master (
        output bus_addr, bus_data, bus_we, bus_start,
        input  bus_q, bus_done, bus_err
    );

    modport slave (
        input  bus_addr, bus_data, bus_we, bus_start,
        output bus_q, bus_done, bus_err
    );
endinterface

// File: rtl/cpu_bus_router.sv
// B322 CPU bus router: decodes a 27-bit word address and runs one transaction at a time
// against SDRAM, boot ROM, VRAM or I/O, flagging timeouts and illegal accesses.
module cpu_bus_router #(
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned ROM_AW  = 9,
    parameter int unsigned VRAM_AW = 14
) (
    input  logic               i_clk,
    input  logic               i_reset,
    cpu_bus_router_if.slave    bus,
    output logic [25:0]        o_sdram_addr,
    output logic [31:0]        o_sdram_data,
    output logic               o_sdram_we,
    output logic               o_sdram_start,
    input  logic [31:0]        i_sdram_q,
    input  logic               i_sdram_done,
    output logic [ROM_AW-1:0]  o_rom_addr,
    input  logic [31:0]        i_rom_q,
    output logic [VRAM_AW-1:0] o_vram_addr,
    output logic [31:0]        o_vram_d,
    output logic               o_vram_we,
    input  logic [31:0]        i_vram_q,
    output logic [7:0]         o_io_addr,
    output logic [31:0]        o_io_data,
    output logic               o_io_we,
    output logic               o_io_start,
    input  logic [31:0]        i_io_q,
    input  logic               i_io_done
);

    localparam int unsigned   CntW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StCapture, StDone} state_e;
    typedef enum logic [1:0] {TgtSdram, TgtIo, TgtVram, TgtRom} tgt_e;

    state_e          r_state;
    state_e          w_state_next;
    tgt_e            r_tgt;
    tgt_e            w_dec_tgt;
    logic            w_dec_bad;
    logic [25:0]     r_addr;
    logic [31:0]     r_data;
    logic            r_we;
    logic            r_err;
    logic [CntW-1:0] r_cnt;
    logic [31:0]     r_bus_q;
    logic            r_bus_done;
    logic            r_bus_err;
    logic            w_tgt_done;
    logic [31:0]     w_tgt_q;
    logic            w_timeout;
    logic            w_remote;

    always_comb begin
        w_dec_tgt = TgtSdram;
        w_dec_bad = 1'b0;
        if (bus.bus_addr[26]) begin
            case (bus.bus_addr[25:24])
                2'b00:   w_dec_tgt = TgtIo;
                2'b01:   w_dec_tgt = TgtVram;
                2'b10: begin
                    w_dec_tgt = TgtRom;
                    w_dec_bad = bus.bus_we;
                end
                default: w_dec_bad = 1'b1;
            endcase
        end
    end

    // Only SDRAM and I/O complete with a done handshake; ROM/VRAM are fixed latency.
    assign w_remote   = (r_tgt == TgtSdram) || (r_tgt == TgtIo);
    assign w_tgt_done = (r_tgt == TgtSdram) ? i_sdram_done : (r_tgt == TgtIo) && i_io_done;
    assign w_tgt_q    = (r_tgt == TgtSdram) ? i_sdram_q : i_io_q;
    assign w_timeout  = (r_cnt == CntMax);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (bus.bus_start) begin
                    w_state_next = w_dec_bad ? StDone : StIssue;
                end
            end
            StIssue: begin
                if (w_remote) begin
                    w_state_next = StWait;
                end else if ((r_tgt == TgtVram) && r_we) begin
                    w_state_next = StDone;
                end else begin
                    w_state_next = StCapture;
                end
            end
            StWait: begin
                if (w_tgt_done || w_timeout) begin
                    w_state_next = StDone;
                end
            end
            StCapture: w_state_next = StDone;
            StDone:    w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_tgt      <= TgtSdram;
            r_addr     <= '0;
            r_data     <= '0;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_bus_q    <= '0;
            r_bus_done <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_bus_done <= (r_state == StDone);
            r_bus_err  <= (r_state == StDone) && r_err;
            case (r_state)
                StIdle: begin
                    if (bus.bus_start) begin
                        r_tgt  <= w_dec_tgt;
                        r_addr <= bus.bus_addr[25:0];
                        r_data <= bus.bus_data;
                        r_we   <= bus.bus_we;
                        r_err  <= w_dec_bad;
                        if (w_dec_bad) begin
                            r_bus_q <= '0;
                        end
                    end
                end
                StIssue: r_cnt <= '0;
                StWait: begin
                    if (w_tgt_done) begin
                        if (!r_we) begin
                            r_bus_q <= w_tgt_q;
                        end
                    end else if (w_timeout) begin
                        r_bus_q <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                StCapture: r_bus_q <= (r_tgt == TgtRom) ? i_rom_q : i_vram_q;
                StDone:    r_err   <= 1'b0;
                default:   ;
            endcase
        end
    end

    // Write enables stay asserted across WAIT so the target sees stable controls.
    assign o_sdram_addr  = r_addr;
    assign o_sdram_data  = r_data;
    assign o_sdram_start = (r_state == StIssue) && (r_tgt == TgtSdram);
    assign o_sdram_we    = r_we && (r_tgt == TgtSdram) &&
                           ((r_state == StIssue) || (r_state == StWait));
    assign o_rom_addr    = r_addr[ROM_AW-1:0];
    assign o_vram_addr   = r_addr[VRAM_AW-1:0];
    assign o_vram_d      = r_data;
    assign o_vram_we     = (r_state == StIssue) && (r_tgt == TgtVram) && r_we;
    assign o_io_addr     = r_addr[7:0];
    assign o_io_data     = r_data;
    assign o_io_start    = (r_state == StIssue) && (r_tgt == TgtIo);
    assign o_io_we       = r_we && (r_tgt == TgtIo) &&
                           ((r_state == StIssue) || (r_state == StWait));

    assign bus.bus_q    = r_bus_q;
    assign bus.bus_done = r_bus_done;
    assign bus.bus_err  = r_bus_err;

endmodule
